// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and data word type for the fifo slice
package fifo_pkg;
    localparam int N_DEF     = 32;
    localparam int DEPTH_DEF = 64;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);
    typedef logic [N_DEF-1:0] word_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port register array with a read-enable gated output register
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);
    logic [N-1:0] buf_mem [0:DEPTH-1];

    // storage deliberately has no reset; stale words become unreachable via the pointers
    always_ff @(posedge clk) begin
        if (we) buf_mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata <= '0;
        else if (re) rdata <= buf_mem[raddr];
    end
endmodule

// File: rtl/fifo.sv
// fifo: single-clock 64x32 FIFO with empty/full flags and a registered read port
module fifo
    import fifo_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] buf_in,
    output logic [N-1:0] buf_out,
    input  logic         wr_en,
    input  logic         rd_en,
    output logic         buf_empty,
    output logic         buf_full
);
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic        wr_acc, rd_acc;

    assign buf_empty = wr_ptr == rd_ptr;
    assign buf_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_acc    = rd_en & !buf_empty;
    // a read in the same cycle frees a slot, so a full FIFO still accepts the write
    assign wr_acc    = wr_en & (!buf_full | rd_acc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(wr_acc);
            rd_ptr <= rd_ptr + (AW+1)'(rd_acc);
            count  <= count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        end
    end

    a_count_flags: assert property (@(posedge clk) disable iff (!rst)
        (buf_empty == (count == '0)) && (buf_full == (count == (AW+1)'(DEPTH))));

    fifo_mem #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (buf_in),
        .re    (rd_acc),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (buf_out)
    );
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed self-checking bench for fifo
module tb_fifo;
    import fifo_pkg::*;
    logic  clk, rst, wr_en, rd_en, buf_empty, buf_full;
    word_t buf_in, buf_out;
    int    checks = 0;
    int    errors = 0;
    word_t q[$];
    word_t d;

    fifo dut (
        .clk       (clk),
        .rst       (rst),
        .buf_in    (buf_in),
        .buf_out   (buf_out),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .buf_empty (buf_empty),
        .buf_full  (buf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; buf_in = '0;
        repeat (2) tick();
        chk("rst_empty", 32'(buf_empty), 1);
        chk("rst_full", 32'(buf_full), 0);
        chk("rst_out", buf_out, 0);
        rst = 1'b1;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_read_out", buf_out, 0);
        chk("empty_read_empty", 32'(buf_empty), 1);

        wr_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            buf_in = word_t'(i);
            tick();
            if (i == 0) chk("first_write_empty", 32'(buf_empty), 0);
            if (i == 62) chk("almost_full", 32'(buf_full), 0);
        end
        chk("fill_full", 32'(buf_full), 1);
        buf_in = 99;
        tick();
        wr_en = 1'b0;
        chk("overflow_full", 32'(buf_full), 1);
        chk("overflow_count", 32'(dut.count), 64);
        chk("overflow_wrptr", 32'(dut.wr_ptr), 64);
        for (int i = 0; i < 64; i++) chk($sformatf("mem_%0d", i), dut.u_mem.buf_mem[i], i);

        rd_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            chk($sformatf("drain_%0d", i), buf_out, i);
        end
        chk("drain_empty", 32'(buf_empty), 1);
        tick();
        rd_en = 1'b0;
        chk("underflow_out", buf_out, 63);
        chk("underflow_rdptr", 32'(dut.rd_ptr), 64);

        wr_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            buf_in = word_t'(100 + i);
            q.push_back(buf_in);
            tick();
        end
        chk("refill_full", 32'(buf_full), 1);
        rd_en = 1'b1;
        buf_in = 77;
        tick();
        q.push_back(77);
        d = q.pop_front();
        chk("simul_out", buf_out, d);
        chk("simul_out_val", buf_out, 100);
        chk("simul_full", 32'(buf_full), 1);
        chk("simul_mem0", dut.u_mem.buf_mem[0], 77);
        wr_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            d = q.pop_front();
            chk($sformatf("drain2_%0d", i), buf_out, d);
        end
        chk("drain2_last", buf_out, 77);
        chk("drain2_empty", 32'(buf_empty), 1);
        rd_en = 1'b0;

        wr_en = 1'b1;
        for (int i = 0; i < 44; i++) begin
            buf_in = word_t'($urandom % 100);
            q.push_back(buf_in);
            tick();
        end
        chk("wrap_pre_count", 32'(dut.count), 44);
        rd_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            buf_in = word_t'($urandom % 100);
            q.push_back(buf_in);
            tick();
            d = q.pop_front();
            chk($sformatf("wrap_out_%0d", i), buf_out, d);
            chk("wrap_count", 32'(dut.count), 44);
            chk("wrap_flags", {30'd0, buf_empty, buf_full}, 0);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            d = q.pop_front();
            chk($sformatf("pre_rst_out_%0d", i), buf_out, d);
        end
        rd_en = 1'b0;
        chk("pre_rst_count", 32'(dut.count), 30);

        #2 rst = 1'b0;
        #1;
        chk("async_empty", 32'(buf_empty), 1);
        chk("async_full", 32'(buf_full), 0);
        chk("async_out", buf_out, 0);
        chk("async_count", 32'(dut.count), 0);
        q.delete();
        tick();
        rst = 1'b1;
        wr_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            buf_in = word_t'(11 * i);
            tick();
        end
        wr_en = 1'b0;
        chk("post_rst_wrptr", 32'(dut.wr_ptr), 3);
        chk("post_rst_slot0", dut.u_mem.buf_mem[0], 11);
        rd_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("post_rst_out_%0d", i), buf_out, 11 * i);
        end
        rd_en = 1'b0;
        chk("post_rst_empty", 32'(buf_empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
